tx_line_arbiter: RTL and testbench
==================================

Name: tx_line_arbiter

Overview:
- Shares the single UartTX serial transmitter between NREQ byte-producing I/O units (card punch, printer and terminal output units, plus a console/debug monitor).
- Access is granted with line-granularity locking. An owner keeps the transmitter until it marks a byte as last or goes idle past a timeout, so text lines from different units never interleave.
- Fairness is round-robin between lines.
- Sits between the output units and UartTX: it drives UartTX load/in and observes UartTX ready.

Parameters:
- NREQ, 2, number of requesting units (2..8).
- TIMEOUT, 1024, idle cycles with the owner's req low before the lock is forcibly released; 0 disables the timeout.
- TW, 11, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-unit "byte valid"; held until the matching ack.
- data  input  7*NREQ  per-unit 7-bit ASCII byte; unit i occupies bits [7i+6:7i].
- last  input  NREQ  per-unit flag, qualified by req: this byte ends the line/block and releases the lock.
- ack  output  NREQ  one-cycle pulse: unit i's byte was accepted.
- grant  output  NREQ  one-hot current lock owner; all zero when idle.
- tx_load  output  1  one-cycle load pulse to UartTX.
- tx_byte  output  7  byte presented to UartTX; valid while tx_load is high, held afterwards.
- tx_ready  input  1  UartTX idle and able to accept a byte.
- busy  output  1  high whenever a lock is held (state != IDLE).
- timeout_evt  output  1  one-cycle pulse when a lock is released by the timeout.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, ptr=0, tmr=0;
  - ack, grant, tx_load, timeout_evt = 0; tx_byte=0; busy=0.
  - A byte already inside UartTX is unaffected. A mid-line owner loses its lock with no ack.
- All outputs are registered.
- States:
  - IDLE: no owner.
  - LOCK: owner is waiting to send.
  - HOLD: one-cycle guard after a load, because UartTX ready falls one cycle after load.
- IDLE transitions:
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, … modulo NREQ.
  - Next edge: grant = one-hot(owner), state = LOCK, tmr = 0.
  - No byte is transferred in the IDLE cycle. Minimum latency from req to tx_load is 2 cycles.
- LOCK, when req[owner] & tx_ready:
  - Next edge: tx_load=1, tx_byte=data[owner], ack[owner]=1, tmr=0, state = HOLD.
  - Record rel = last[owner].
- LOCK, when req[owner]=0:
  - tmr increments each cycle.
  - When TIMEOUT != 0 and tmr == TIMEOUT-1, next edge: state = IDLE, grant=0, timeout_evt=1, ptr = (owner+1) mod NREQ.
- LOCK, when req[owner]=1 but tx_ready=0: wait; tmr holds (tmr counts only while req is low).
- HOLD:
  - tx_load and ack return to 0; no load is ever issued in HOLD.
  - If rel: state = IDLE, grant=0, ptr = (owner+1) mod NREQ.
  - Else state = LOCK.
- Back-to-back throughput is therefore bounded by UartTX, never by the arbiter.
- Requests from non-owners are ignored while locked and never acked. They are served on a later IDLE scan.
- The owner may drop req between bytes mid-line; the lock is retained (subject to the timeout).
- Simultaneous requests in IDLE: the round-robin pointer decides.
  - With NREQ=2, ptr=1 and req=2'b11, unit 1 wins.
- A last byte arriving on the same cycle another unit raises req: the other unit is granted no earlier than the cycle after HOLD.
- The pointer wraps from NREQ-1 to 0.
- The timeout counter saturates and cannot wrap.
- data/last from non-owners are don't-care.
- X on the req bits of non-owners must not affect outputs.

Test Plan:
1. NREQ=2. Unit 0 sends "AB" with last on B; tx_ready is always 1 → grant=01 at cycle 1; tx_load at cycles 2 and 4 with tx_byte 65 then 66; ack[0] pulses at 2 and 4; busy falls at cycle 5; ptr=1.
2. Both units request continuously, each sending 1-byte lines with last=1 → grants alternate 01, 10, 01, …; tx_byte alternates between the two units' data; no unit is granted twice in a row.
3. Unit 0 holds the lock mid-line while unit 1 requests; tx_ready is held low 20 cycles after the first byte → no ack[1] and no tx_load during the stall; unit 0's second byte loads on the first cycle after tx_ready returns high.
4. TIMEOUT=8. Unit 0 sends one byte with last=0, then drops req; unit 1 requests → timeout_evt pulses 8 cycles after the first idle cycle of unit 0; unit 1 is granted on the following cycle.
5. Assert reset asynchronously (between clock edges) during HOLD → all outputs are 0 immediately; after release with only req[1]=1, grant=10 (ptr=0 scans to unit 1); no spurious tx_load.
6. NREQ=4, ptr=3, req=4'b1001 → unit 3 is granted, then unit 0 (wrap-around order).

Source files
------------

// File: rtl/tx_line_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte producers.
// The lock is held per line: it is released by a byte marked last, or by an idle timeout.
module tx_line_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] data,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              tx_load,
  output logic [6:0]        tx_byte,
  input  logic              tx_ready,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] TMR_MAX = '1;
  localparam logic [TW-1:0] TMR_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOCK, HOLD} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [TW-1:0]   tmr, tmr_nx;
  logic            rel, rel_nx;
  logic [NREQ-1:0] ack_nx, grant_nx;
  logic            tx_load_nx, busy_nx, timeout_nx;
  logic [6:0]      tx_byte_nx;

  logic            found;
  logic [IW-1:0]   pick;
  logic            owner_req, owner_last;
  logic [6:0]      owner_data;
  logic [IW-1:0]   owner_succ;

  // Only the owner's bits are ever looked at while locked, so non-owner X cannot leak out.
  assign owner_req  = req[owner];
  assign owner_last = last[owner];
  assign owner_data = data[7*int'(owner) +: 7];
  assign owner_succ = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    owner_nx   = owner;
    tmr_nx     = tmr;
    rel_nx     = rel;
    ack_nx     = '0;
    grant_nx   = grant;
    tx_load_nx = 1'b0;
    tx_byte_nx = tx_byte;
    timeout_nx = 1'b0;

    case (state)
      IDLE: begin
        grant_nx = '0;
        if (found) begin
          owner_nx = pick;
          grant_nx = NREQ'(1) << pick;
          tmr_nx   = '0;
          state_nx = LOCK;
        end
      end

      LOCK: begin
        if (owner_req) begin
          // The idle timer is frozen while the owner is waiting on a busy transmitter.
          if (tx_ready) begin
            tx_load_nx = 1'b1;
            tx_byte_nx = owner_data;
            ack_nx     = NREQ'(1) << owner;
            tmr_nx     = '0;
            rel_nx     = owner_last;
            state_nx   = HOLD;
          end
        end else if ((TIMEOUT != 0) && (tmr == TMR_LIM)) begin
          state_nx   = IDLE;
          grant_nx   = '0;
          timeout_nx = 1'b1;
          ptr_nx     = owner_succ;
          tmr_nx     = '0;
        end else if (tmr != TMR_MAX) begin
          tmr_nx = tmr + 1'b1;
        end
      end

      HOLD: begin
        // Transmitter ready only falls the cycle after load, so never reload from here.
        if (rel) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = owner_succ;
        end else begin
          state_nx = LOCK;
        end
      end

      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      tmr         <= '0;
      rel         <= 1'b0;
      ack         <= '0;
      grant       <= '0;
      tx_load     <= 1'b0;
      tx_byte     <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      owner       <= owner_nx;
      tmr         <= tmr_nx;
      rel         <= rel_nx;
      ack         <= ack_nx;
      grant       <= grant_nx;
      tx_load     <= tx_load_nx;
      tx_byte     <= tx_byte_nx;
      busy        <= busy_nx;
      timeout_evt <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_tx_line_arbiter.sv
// Scoreboard bench for tx_line_arbiter: a 2-unit instance with a short timeout and a
// 4-unit instance for pointer wrap-around.
module tb_tx_line_arbiter;

  typedef struct {
    logic [6:0] b;
    logic       l;
  } item_t;

  typedef struct {
    logic [6:0] b;
    logic [3:0] a;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_ready = 1'b1;

  logic [1:0]  req2 = '0;
  logic [13:0] data2 = '0;
  logic [1:0]  last2 = '0;
  logic [1:0]  ack2, grant2;
  logic        tx_load2, busy2, timeout_evt2;
  logic [6:0]  tx_byte2;

  logic [3:0]  req4 = '0;
  logic [27:0] data4 = '0;
  logic [3:0]  last4 = '0;
  logic [3:0]  ack4, grant4;
  logic        tx_load4, busy4, timeout_evt4;
  logic [6:0]  tx_byte4;

  item_t uq2 [2][$];
  item_t uq4 [4][$];
  exp_t  exp2 [$];
  exp_t  exp4 [$];

  int checks = 0;
  int errors = 0;

  tx_line_arbiter #(.NREQ(2), .TIMEOUT(8), .TW(4)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .data(data2), .last(last2),
    .ack(ack2), .grant(grant2), .tx_load(tx_load2), .tx_byte(tx_byte2),
    .tx_ready(tx_ready), .busy(busy2), .timeout_evt(timeout_evt2)
  );

  tx_line_arbiter #(.NREQ(4), .TIMEOUT(1024), .TW(11)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .data(data4), .last(last4),
    .ack(ack4), .grant(grant4), .tx_load(tx_load4), .tx_byte(tx_byte4),
    .tx_ready(tx_ready), .busy(busy4), .timeout_evt(timeout_evt4)
  );

  always #5 clk = ~clk;

  // Unit models: present the queue head, retire it on ack, drop req when empty.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack2[i] && uq2[i].size() > 0) void'(uq2[i].pop_front());
      if (uq2[i].size() > 0) begin
        req2[i] = 1'b1;
        data2[i*7 +: 7] = uq2[i][0].b;
        last2[i] = uq2[i][0].l;
      end else begin
        req2[i] = 1'b0;
        last2[i] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ack4[i] && uq4[i].size() > 0) void'(uq4[i].pop_front());
      if (uq4[i].size() > 0) begin
        req4[i] = 1'b1;
        data4[i*7 +: 7] = uq4[i][0].b;
        last4[i] = uq4[i][0].l;
      end else begin
        req4[i] = 1'b0;
        last4[i] = 1'b0;
      end
    end
  end

  // Monitors: every load or ack must match the next expected transfer.
  always @(negedge clk) begin
    exp_t e;
    if (tx_load2 || ack2 != '0) begin
      checks++;
      if (exp2.size() == 0) begin
        errors++;
        $display("[TB] FAIL dut2_xfer: unexpected load=%0b byte=%0d ack=%b", tx_load2, tx_byte2, ack2);
      end else begin
        e = exp2.pop_front();
        if (!tx_load2 || tx_byte2 !== e.b || {2'b00, ack2} !== e.a) begin
          errors++;
          $display("[TB] FAIL dut2_xfer: got load=%0b byte=%0d ack=%b, want load=1 byte=%0d ack=%b",
                   tx_load2, tx_byte2, ack2, e.b, e.a[1:0]);
        end
      end
    end
    if (tx_load4 || ack4 != '0) begin
      checks++;
      if (exp4.size() == 0) begin
        errors++;
        $display("[TB] FAIL dut4_xfer: unexpected load=%0b byte=%0d ack=%b", tx_load4, tx_byte4, ack4);
      end else begin
        e = exp4.pop_front();
        if (!tx_load4 || tx_byte4 !== e.b || ack4 !== e.a) begin
          errors++;
          $display("[TB] FAIL dut4_xfer: got load=%0b byte=%0d ack=%b, want load=1 byte=%0d ack=%b",
                   tx_load4, tx_byte4, ack4, e.b, e.a);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic apply_stimulus2(input int unit, input logic [6:0] b, input logic l);
    item_t it;
    exp_t  e;
    it.b = b;
    it.l = l;
    uq2[unit].push_back(it);
  endtask

  task automatic expect2(input logic [6:0] b, input logic [3:0] a);
    exp_t e;
    e.b = b;
    e.a = a;
    exp2.push_back(e);
  endtask

  task automatic apply_stimulus4(input int unit, input logic [6:0] b, input logic l);
    item_t it;
    exp_t  e;
    it.b = b;
    it.l = l;
    uq4[unit].push_back(it);
    e.b = b;
    e.a = 4'(1) << unit;
    exp4.push_back(e);
  endtask

  task automatic wait_ack2(input int unit, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (ack2[unit]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s: ack[%0d] got none, want one within %0d cycles", name, unit, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp2.size() == 0 && exp4.size() == 0 && uq2[0].size() == 0 && uq2[1].size() == 0 &&
          uq4[0].size() == 0 && uq4[1].size() == 0 && uq4[2].size() == 0 && uq4[3].size() == 0 &&
          !busy2 && !busy4)
        done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s: pending exp2=%0d exp4=%0d busy2=%0b busy4=%0b, want all drained",
               name, exp2.size(), exp4.size(), busy2, busy4);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    bit hit;

    // Reset state
    @(negedge clk);
    check_output("reset_outs2", {grant2, ack2, tx_load2, tx_byte2, busy2, timeout_evt2}, '0);
    check_output("reset_outs4", {grant4, ack4, tx_load4, tx_byte4, busy4, timeout_evt4}, '0);
    #2 reset = 1'b0;

    // Line "AB" from unit 0 with a permanently ready transmitter
    apply_stimulus2(0, 7'd65, 1'b0);
    apply_stimulus2(0, 7'd66, 1'b1);
    expect2(7'd65, 4'b0001);
    expect2(7'd66, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    check_output("t1_grant", grant2, 2'b01);
    check_output("t1_noload_c1", tx_load2, 1'b0);
    @(negedge clk);
    check_output("t1_load_c2", tx_load2, 1'b1);
    @(negedge clk);
    check_output("t1_hold_c3", {tx_load2, busy2}, 2'b01);
    @(negedge clk);
    check_output("t1_load_c4", {tx_load2, tx_byte2}, {1'b1, 7'd66});
    @(negedge clk);
    check_output("t1_release", {busy2, grant2}, 3'b000);
    wait_idle(20, "t1_drain");

    // Both units with one-byte lines: ptr is now 1, so unit 1 leads and they alternate
    #2;
    apply_stimulus2(0, 7'd97, 1'b1);
    apply_stimulus2(0, 7'd99, 1'b1);
    apply_stimulus2(1, 7'd98, 1'b1);
    apply_stimulus2(1, 7'd100, 1'b1);
    expect2(7'd98, 4'b0010);
    expect2(7'd97, 4'b0001);
    expect2(7'd100, 4'b0010);
    expect2(7'd99, 4'b0001);
    wait_idle(60, "t2_drain");

    // Unit 0 holds a line through a transmitter stall while unit 1 waits
    #2;
    apply_stimulus2(0, 7'd88, 1'b0);
    apply_stimulus2(0, 7'd89, 1'b1);
    expect2(7'd88, 4'b0001);
    expect2(7'd89, 4'b0001);
    expect2(7'd90, 4'b0010);
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (grant2 == 2'b01) hit = 1'b1;
    end
    check_output("t3_grant0", {31'd0, hit}, 32'd1);
    #2 apply_stimulus2(1, 7'd90, 1'b1);
    wait_ack2(0, 10, "t3_first_ack");
    tx_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_output("t3_stall_quiet", {tx_load2, ack2}, 3'b000);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check_output("t3_resume_load", {tx_load2, tx_byte2}, {1'b1, 7'd89});
    wait_idle(40, "t3_drain");

    // Owner goes quiet mid-line; timeout releases it to unit 1
    #2;
    apply_stimulus2(0, 7'd80, 1'b0);
    apply_stimulus2(1, 7'd81, 1'b1);
    expect2(7'd80, 4'b0001);
    expect2(7'd81, 4'b0010);
    wait_ack2(0, 10, "t4_ack");
    cnt = 0;
    hit = 1'b0;
    for (int c = 1; c <= 20 && !hit; c++) begin
      @(negedge clk);
      if (timeout_evt2) begin
        hit = 1'b1;
        cnt = c;
      end
    end
    check_output("t4_timeout_cycles", cnt, 9);
    check_output("t4_released", {grant2, busy2}, 3'b000);
    @(negedge clk);
    check_output("t4_next_grant", {grant2, timeout_evt2}, 3'b100);
    wait_idle(40, "t4_drain");

    // Asynchronous reset during HOLD, then unit 1 alone
    #2;
    apply_stimulus2(0, 7'd82, 1'b0);
    expect2(7'd82, 4'b0001);
    wait_ack2(0, 10, "t5_ack");
    #2 reset = 1'b1;
    #1 check_output("t5_async_reset", {grant2, ack2, tx_load2, tx_byte2, busy2, timeout_evt2}, '0);
    apply_stimulus2(1, 7'd84, 1'b1);
    expect2(7'd84, 4'b0010);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_output("t5_grant_after_reset", {grant2, tx_load2}, 3'b100);
    wait_idle(40, "t5_drain");

    // Four units: serve unit 2 to move ptr to 3, then req 1001 wraps 3 -> 0
    #2;
    apply_stimulus4(2, 7'd50, 1'b1);
    wait_idle(20, "t6_prime");
    #2;
    apply_stimulus4(3, 7'd51, 1'b1);
    apply_stimulus4(0, 7'd48, 1'b1);
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (grant4 != '0) hit = 1'b1;
    end
    check_output("t6_first_grant", grant4, 4'b1000);
    wait_idle(40, "t6_drain");

    check_output("final_exp_empty", exp2.size() + exp4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
